// File: rtl/dram_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_seq_pkg
// Description : Shared types and default timing for the DRAM address
//               sequencer: controller state encoding, default parameter
//               values and the width of the phase-length counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dram_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ROW     = 3'd1,
    S_RAS     = 3'd2,
    S_COL     = 3'd3,
    S_CAS     = 3'd4,
    S_PRE     = 3'd5,
    S_REF_ROW = 3'd6,
    S_REF_RAS = 3'd7
  } state_t;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_CAS_CYC        = 2;
  localparam int DEF_PRE_CYC        = 2;
  localparam int DEF_RAS_REF_CYC    = 2;
  localparam int DEF_REFRESH_PERIOD = 64;

  // Width of the counter that times the multi-cycle phases (CAS, PRE, REF_RAS).
  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/dram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module      : dram_refresh_timer
// Description : Free-running refresh period counter, refresh-pending flag and
//               the row counter used by RAS-only refresh.
// Ports       : clk, nrst     - clock, async active-low reset
//               clear         - refresh has been taken (drops pending)
//               inc           - advance refresh row by one (mod 2^ADDR_W)
//               pending       - a refresh is owed
//               row           - next row to refresh
// Revision    : 1.0 - initial release
// ============================================================================
module dram_refresh_timer #(
  parameter int ADDR_W         = 8,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear,
  input  logic              inc,
  output logic              pending,
  output logic [ADDR_W-1:0] row
);

  localparam int            TW     = $clog2(REFRESH_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(REFRESH_PERIOD - 1);

  logic [TW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == T_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      pending <= 1'b0;
      row     <= '0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
      // A wrap takes priority over clear so a request arriving in the same
      // cycle the previous one is consumed is not lost; it never accumulates.
      if (w_wrap)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
      if (inc)
        row <= row + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dram_addr_sequencer
// Description : Multiplexes a latched 2*ADDR_W CPU address onto the DRAM
//               address bus and sequences nRAS/nCAS/nWE, with RAS-only
//               refresh and a req/ack handshake.
// Ports       : clk, nrst           - clock, async active-low reset
//               req, we, addr       - access request (level), write flag,
//                                     address (row = upper half)
//               noe                 - active-low output enable for ma
//               ma, sel             - DRAM address, row(0)/column(1) select
//               nras, ncas, nwe     - DRAM strobes, active-low
//               ack                 - one-cycle data-phase-complete pulse
//               busy                - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module dram_addr_sequencer
  import dram_seq_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CAS_CYC        = DEF_CAS_CYC,
  parameter int PRE_CYC        = DEF_PRE_CYC,
  parameter int RAS_REF_CYC    = DEF_RAS_REF_CYC,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                req,
  input  logic                we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic                noe,
  output logic [ADDR_W-1:0]   ma,
  output logic                sel,
  output logic                nras,
  output logic                ncas,
  output logic                nwe,
  output logic                ack,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(RAS_REF_CYC - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2*ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_W-1:0]     r_ma, w_ma_nxt;
  logic                  w_sel_nxt, w_nras_nxt, w_ncas_nxt, w_nwe_nxt, w_ack_nxt;
  logic                  w_ref_clear, w_ref_inc, w_pending;
  logic [ADDR_W-1:0]     w_row;

  dram_refresh_timer #(
    .ADDR_W         (ADDR_W),
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (w_ref_clear),
    .inc     (w_ref_inc),
    .pending (w_pending),
    .row     (w_row)
  );

  // Next state, phase counter and address latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_ref_clear = 1'b0;
    w_ref_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_state_nxt = S_REF_ROW;
        end else if (req) begin
          w_state_nxt = S_ROW;
          w_addr_nxt  = addr;
          w_we_nxt    = we;
        end
      end
      S_ROW: w_state_nxt = S_RAS;
      S_RAS: w_state_nxt = S_COL;
      S_COL: w_state_nxt = S_CAS;
      S_CAS: begin
        if (r_cnt == CAS_LAST) w_state_nxt = S_PRE;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_PRE: begin
        if (r_cnt == PRE_LAST) w_state_nxt = S_IDLE;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_REF_ROW: begin
        w_ref_clear = 1'b1;
        w_state_nxt = S_REF_RAS;
      end
      S_REF_RAS: begin
        if (r_cnt == REF_LAST) begin
          w_state_nxt = S_PRE;
          w_ref_inc   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_ma_nxt   = r_ma;
    w_sel_nxt  = 1'b0;
    w_nras_nxt = 1'b1;
    w_ncas_nxt = 1'b1;
    w_nwe_nxt  = 1'b1;
    case (w_state_nxt)
      S_ROW: w_ma_nxt = w_addr_nxt[2*ADDR_W-1:ADDR_W];
      S_RAS: w_nras_nxt = 1'b0;
      S_COL: begin
        w_nras_nxt = 1'b0;
        w_sel_nxt  = 1'b1;
        w_ma_nxt   = w_addr_nxt[ADDR_W-1:0];
      end
      S_CAS: begin
        w_nras_nxt = 1'b0;
        w_sel_nxt  = 1'b1;
        w_ncas_nxt = 1'b0;
        w_nwe_nxt  = ~w_we_nxt;
      end
      S_REF_ROW: w_ma_nxt = w_row;
      S_REF_RAS: w_nras_nxt = 1'b0;
      default: ;
    endcase
    w_ack_nxt = (w_state_nxt == S_CAS) && (w_cnt_nxt == CAS_LAST);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_ma    <= '0;
      sel     <= 1'b0;
      nras    <= 1'b1;
      ncas    <= 1'b1;
      nwe     <= 1'b1;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_ma    <= w_ma_nxt;
      sel     <= w_sel_nxt;
      nras    <= w_nras_nxt;
      ncas    <= w_ncas_nxt;
      nwe     <= w_nwe_nxt;
      ack     <= w_ack_nxt;
      busy    <= (w_state_nxt != S_IDLE);
    end
  end

  // The output-enable gate stays combinational, as on the discrete mux.
  assign ma = noe ? '0 : r_ma;

endmodule
`default_nettype wire

// File: tb/tb_dram_addr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dram_addr_sequencer
// Description : Scoreboard bench for dram_addr_sequencer. The driver queues
//               the expected access for every request; a negedge monitor
//               rebuilds each nRAS-low episode from the pins and compares it
//               with the queue (accesses) or a refresh-row model (refreshes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_addr_sequencer;

  localparam int ADDR_W         = 8;
  localparam int CAS_CYC        = 2;
  localparam int PRE_CYC        = 2;
  localparam int RAS_REF_CYC    = 2;
  localparam int REFRESH_PERIOD = 64;

  // Expected per-cycle pins for an access, bit i = i-th edge after sampling.
  localparam bit [7:0] T_NRAS = 8'b1110_0001;
  localparam bit [7:0] T_NCAS = 8'b1110_0111;
  localparam bit [7:0] T_SEL  = 8'b0001_1100;
  localparam bit [7:0] T_ACK  = 8'b0001_0000;
  localparam bit [7:0] T_BUSY = 8'b0111_1111;

  localparam int LAT_ACCESS  = 2 + CAS_CYC;
  localparam int LAT_REFRESH = (1 + RAS_REF_CYC + PRE_CYC) + 1 + LAT_ACCESS;

  logic                clk  = 1'b0;
  logic                nrst = 1'b0;
  logic                req  = 1'b0;
  logic                we   = 1'b0;
  logic                noe  = 1'b0;
  logic [2*ADDR_W-1:0] addr = '0;
  logic [ADDR_W-1:0]   ma;
  logic                sel, nras, ncas, nwe, ack, busy;

  always #5 clk = ~clk;

  dram_addr_sequencer #(
    .ADDR_W         (ADDR_W),
    .CAS_CYC        (CAS_CYC),
    .PRE_CYC        (PRE_CYC),
    .RAS_REF_CYC    (RAS_REF_CYC),
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .noe  (noe),
    .ma   (ma),
    .sel  (sel),
    .nras (nras),
    .ncas (ncas),
    .nwe  (nwe),
    .ack  (ack),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic        w;
  } acc_t;
  acc_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       nras_p = 1'b1, ncas_p = 1'b1;
  bit         ep_active = 0, ep_cas = 0, ep_row_noe = 0, ep_col_noe = 0;
  logic [7:0] ep_row = '0, ep_col = '0;
  int         ep_ras_cyc = 0, ep_cas_cyc = 0, ep_nwe_cyc = 0, ep_ack = 0;
  int         exp_ref_row = 0;
  int         ref_seen = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      ep_active   = 0;
      nras_p      = 1'b1;
      ncas_p      = 1'b1;
      exp_ref_row = 0;
    end else begin
      if (!ncas) check("ncas_low_needs_nras_low", nras, 0);
      if (ncas)  check("nwe_high_outside_cas", nwe, 1);
      if (noe)   check("noe_forces_ma_zero", ma, 0);
      if (nras_p && !nras) begin
        ep_active  = 1;
        ep_cas     = 0;
        ep_row     = ma;
        ep_row_noe = noe;
        ep_ras_cyc = 0;
        ep_cas_cyc = 0;
        ep_nwe_cyc = 0;
        ep_ack     = 0;
        check("sel_low_at_ras", sel, 0);
      end
      if (ncas_p && !ncas) begin
        ep_cas     = 1;
        ep_col     = ma;
        ep_col_noe = noe;
        check("sel_high_at_cas", sel, 1);
      end
      if (!nras) ep_ras_cyc++;
      if (!ncas) ep_cas_cyc++;
      if (!ncas && !nwe) ep_nwe_cyc++;
      if (ack) begin
        if (ep_active) ep_ack++;
        else check("ack_outside_access", ack, 0);
      end
      if (!nras_p && nras && ep_active) begin
        ep_active = 0;
        if (ep_cas) begin
          check("access_was_requested", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            acc_t e;
            e = exp_q.pop_front();
            check("access_row", ep_row, ep_row_noe ? 8'h00 : e.a[15:8]);
            check("access_col", ep_col, ep_col_noe ? 8'h00 : e.a[7:0]);
            check("access_ras_cycles", ep_ras_cyc, 2 + CAS_CYC);
            check("access_cas_cycles", ep_cas_cyc, CAS_CYC);
            check("access_nwe_cycles", ep_nwe_cyc, e.w ? CAS_CYC : 0);
            check("access_ack_count", ep_ack, 1);
          end
        end else begin
          check("refresh_row", ep_row, ep_row_noe ? 8'h00 : 8'(exp_ref_row));
          check("refresh_ras_cycles", ep_ras_cyc, RAS_REF_CYC);
          check("refresh_no_ack", ep_ack, 0);
          exp_ref_row = (exp_ref_row + 1) % (1 << ADDR_W);
          ref_seen++;
        end
      end
      nras_p = nras;
      ncas_p = ncas;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("wait_idle_bound", ok, 1);
  endtask

  // Called at posedge+1. lat = edges from sampling edge to the ack edge.
  task automatic do_access(input logic [15:0] a, input logic w, input bit timed, output int lat);
    acc_t e;
    int   n_ack, ack_at, idle_at;
    bit   done;
    wait_idle();
    req  = 1'b1;
    addr = a;
    we   = w;
    e.a  = a;
    e.w  = w;
    exp_q.push_back(e);
    n_ack = 0; ack_at = -1; idle_at = -1; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (sel) begin
        addr = 16'($urandom);   // latched already: must be ignored
        we   = 1'($urandom);
      end
      if (timed && i < 8) begin
        check("seq_nras", nras, T_NRAS[i]);
        check("seq_ncas", ncas, T_NCAS[i]);
        check("seq_sel",  sel,  T_SEL[i]);
        check("seq_ack",  ack,  T_ACK[i]);
        check("seq_busy", busy, T_BUSY[i]);
        if (i == 0) check("seq_ma_row", ma, noe ? 8'h00 : a[15:8]);
        if (i == 2) check("seq_ma_col", ma, noe ? 8'h00 : a[7:0]);
      end
      if (ack) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = i;
          req    = 1'b0;
        end
      end
      if (ack_at >= 0 && !busy) begin
        done    = 1;
        idle_at = i;
      end
    end
    req = 1'b0;
    check("access_completed", done, 1);
    check("ack_pulses", n_ack, 1);
    check("ack_to_idle", idle_at - ack_at, PRE_CYC + 1);
    lat = ack_at;
  endtask

  task automatic apply_reset_and_release();
    nrst = 1'b0;
    req  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    nrst = 1'b1;   // the edge just before this is edge 0
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, d;
    bit ok;

    // Reset values, then unchanged for 3 idle cycles.
    repeat (3) @(posedge clk); #1;
    check("rst_ma", ma, 0);
    check("rst_nras", nras, 1);
    check("rst_ncas", ncas, 1);
    check("rst_nwe", nwe, 1);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ma", ma, 0);
    check("idle_nras", nras, 1);
    check("idle_ncas", ncas, 1);
    check("idle_nwe", nwe, 1);
    check("idle_sel", sel, 0);
    check("idle_busy", busy, 0);

    // Directed read with output enabled, write with output disabled.
    noe = 1'b0;
    do_access(16'hA55A, 1'b0, 1'b1, lat);
    check("read_latency", lat, LAT_ACCESS);
    noe = 1'b1;
    do_access(16'h1234, 1'b1, 1'b1, lat);
    check("write_latency", lat, LAT_ACCESS);
    noe = 1'b0;

    // Long idle run: periodic refreshes, row counter wraps past 0xFF.
    r0 = ref_seen;
    repeat (260 * REFRESH_PERIOD) @(posedge clk);
    #1;
    d = ref_seen - r0;
    check("refresh_count_window", (d >= 259 && d <= 261), 1);

    // Request presented in the cycle pending sets: refresh goes first.
    apply_reset_and_release();
    repeat (REFRESH_PERIOD) @(posedge clk);
    #1;
    do_access(16'h5AA5, 1'b0, 1'b0, lat);
    check("refresh_first_latency", lat, LAT_REFRESH);

    // Reset in the middle of CAS.
    wait_idle();
    req = 1'b1; addr = 16'hBEEF; we = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!ncas) begin
        ok = 1;
        break;
      end
    end
    check("reached_cas", ok, 1);
    nrst = 1'b0;
    #1;
    check("midrst_nras", nras, 1);
    check("midrst_ncas", ncas, 1);
    check("midrst_nwe", nwe, 1);
    check("midrst_ma", ma, 0);
    check("midrst_ack", ack, 0);
    check("midrst_busy", busy, 0);
    apply_reset_and_release();
    do_access(16'h0FF0, 1'b1, 1'b1, lat);
    check("post_reset_latency", lat, LAT_ACCESS);

    // Randomized traffic with random gaps so refreshes interleave.
    for (int n = 0; n < 40; n++) begin
      noe = ($urandom_range(0, 3) == 0);
      do_access(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, lat);
      check("random_latency", (lat == LAT_ACCESS || lat == LAT_REFRESH), 1);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    noe = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_addr_sequencer.md
# dram_addr_sequencer

Parametrised successor to the quad 2-to-1 address multiplexer: multiplexes a latched 2×ADDR_W-bit CPU address onto an ADDR_W-bit DRAM address bus and generates the nRAS/nCAS/nWE strobes and select timing that the discrete mux previously relied on external glue for. It adds an output-enable, a RAS-only refresh engine with its own row counter, and a request/acknowledge handshake. It sits between the CPU bus interface and the DRAM array.

## Interface
- ADDR_W, 8, row/column width; CPU address is 2×ADDR_W bits (row = upper half, column = lower half)
- CAS_CYC, 2, cycles nCAS held low per access (≥1)
- PRE_CYC, 2, precharge cycles after every access or refresh (≥1)
- RAS_REF_CYC, 2, cycles nRAS held low per refresh (≥1)
- REFRESH_PERIOD, 64, clock cycles between refresh requests (≥8)
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- req  in  1  access request, level, held until ack
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  2×ADDR_W  CPU address, sampled with req
- noe  in  1  output enable, active-low; 1 forces ma to all zeros
- ma  out  ADDR_W  multiplexed DRAM address
- sel  out  1  mux select: 0 = row/refresh row, 1 = column
- nras  out  1  row strobe, active-low
- ncas  out  1  column strobe, active-low
- nwe  out  1  write strobe, active-low
- ack  out  1  one-cycle pulse: access data phase complete
- busy  out  1  1 in every state except IDLE

## Operation
- Reset (async, immediate, also mid-operation): state IDLE; ma=0, sel=0, nras=ncas=nwe=1, ack=0, busy=0; refresh timer=0, refresh row=0, pending=0; latched address/we=0.
- All outputs registered except the noe gate: ma = noe ? 0 : ma_reg (combinational, matches discrete-mux behaviour).
- States: IDLE, ROW, RAS, COL, CAS, PRE, REF_ROW, REF_RAS.
- IDLE: if pending -> REF_ROW (refresh wins over simultaneous req); else if req -> ROW, latching addr and we.
- ROW (1 cycle): ma=row, sel=0, nras=1 (row setup).
- RAS (1 cycle): nras=0.
- COL (1 cycle): sel=1, ma=col, nras=0.
- CAS (CAS_CYC cycles): ncas=0, nwe=~we; ack=1 in last CAS cycle only.
- PRE (PRE_CYC cycles): nras=ncas=nwe=1, sel=0, ma holds last value; -> IDLE.
- REF_ROW (1 cycle): ma=refresh row, sel=0, clears pending. REF_RAS (RAS_REF_CYC cycles): nras=0, ncas=1, nwe=1; on exit refresh row increments mod 2^ADDR_W; -> PRE.
- Refresh timer free-runs 0..REFRESH_PERIOD-1 regardless of state; wrap sets pending. Wrap while pending already set: stays set (no accumulation). Wrap in same cycle as REF_ROW clears pending: pending remains set.
- req still high in IDLE after ack starts a new access; requester must drop req the cycle after ack to avoid it.
- addr/we changes while busy have no effect.

## Timing
- req sampled high at edge k in IDLE, no pending: ROW after k, nras low after k+1, ncas low after k+3, ack high after edge k+2+CAS_CYC, IDLE after k+3+CAS_CYC+PRE_CYC (defaults: 7 cycles request-to-idle).
- Refresh: 1+RAS_REF_CYC+PRE_CYC cycles (default 5).
- Worst-case access latency = refresh length + access length.
- nras and ncas never both change toward active in the same cycle; ncas never low while nras high.

## Structure
- Package dram_seq_pkg: state encoding enum, default timing constants.
- Sub-module dram_refresh_timer: period counter, pending flag, refresh row counter (ADDR_W bits, increment input).
- Row/column selection inline in the sequencer; no separate mux instance.

## Test plan
- Reset: nrst=0 -> ma=0, nras=ncas=nwe=1, ack=0, busy=0; release, idle 3 cycles -> unchanged.
- Read addr=16'hA55A, we=0, noe=0 -> ma=8'hA5 while nras falls, ma=8'h5A with sel=1 before ncas falls, nwe=1, single ack, busy back to 0 after 7 cycles.
- Write addr=16'h1234, we=1, noe=1 -> ma=0 throughout, nwe=0 exactly while ncas=0, strobe sequence unchanged.
- Run 3×REFRESH_PERIOD cycles idle -> three refreshes with ma=0,1,2, ncas never low; force row=8'hFF -> next refresh ma=8'hFF then 8'h00.
- req asserted in the cycle pending sets -> refresh executes first, access follows, exactly one ack.
- nrst low during CAS -> strobes high and ma=0 immediately, no ack; subsequent access completes normally.
